imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the IF fetch path and the program loader / debug requester.
//  Sits between IF (inst_mem_read_addr/enable) and the imem macro; the memory has variable latency with a ready handshake.
//  Drives fetch_stall into IF, where it is ORed with EX_stall so the PC holds while a fetch is pending.
//  IF redirects (branch mispredict or jump) kill an in-flight fetch response.
// PARAMETERS
//  ADDR_W   32  address width, byte address, word aligned
//  DATA_W   32  data width
//  TIMEOUT  15  max cycles waiting for mem_ready before abort; counter is $clog2(TIMEOUT+1) bits
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  if_req     in   1       IF fetch request, held until if_grant
//  if_addr    in   ADDR_W  fetch address (pc)
//  if_flush   in   1       IF redirect: discard any outstanding fetch response
//  if_grant   out  1       fetch accepted this cycle
//  if_rvalid  out  1       1-cycle pulse, if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction
//  fetch_stall out 1       IF must hold its PC
//  ld_req     in   1       loader request, held until ld_grant
//  ld_we      in   1       1 = write, 0 = read
//  ld_addr    in   ADDR_W  loader address
//  ld_wdata   in   DATA_W  loader write data
//  ld_grant   out  1       loader request accepted this cycle
//  ld_done    out  1       1-cycle pulse, loader transaction complete
//  ld_rdata   out  DATA_W  loader read data, valid with ld_done
//  mem_en     out  1       memory command strobe, 1 cycle per transaction
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ready
//  mem_ready  in   1       memory completes the current command
//  err        out  1       sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, rr=IF-preferred, kill=0, counter=0. All outputs 0.
//  - FSM states: IDLE, BUSY_IF, BUSY_LD. At most one transaction is outstanding.
//  - IDLE, one request: grant it. Assert if_grant or ld_grant, and in the same cycle drive mem_en=1 with
//    mem_addr/mem_we/mem_wdata from the winner (combinational). Next state is BUSY_IF or BUSY_LD.
//  - IDLE, both requests: round-robin. rr points to the preferred requester and flips to the other after each grant.
//  - BUSY_*: mem_en=0. mem_addr/we/wdata hold the latched command. Counter increments each cycle.
//  - mem_ready in BUSY_IF: register mem_rdata into if_rdata. Pulse if_rvalid the next cycle, unless kill is set.
//    Next state is IDLE. The next grant can issue in the cycle after mem_ready (2-cycle minimum per transaction).
//  - mem_ready in BUSY_LD: ld_rdata <= mem_rdata. Pulse ld_done the next cycle (writes also pulse ld_done). Next state is IDLE.
//  - kill: set by if_flush in BUSY_IF, including the mem_ready cycle. Cleared on return to IDLE.
//    if_flush in IDLE or BUSY_LD is ignored; IF re-requests with its new pc.
//  - Timeout: counter reaches TIMEOUT with no mem_ready. Abort to IDLE, set err=1, no rvalid/done.
//    A late mem_ready arriving in IDLE is ignored.
//  - fetch_stall = (if_req & ~if_grant) | (state==BUSY_IF).
//  - mem_ready in IDLE is ignored.
//  - if_grant and ld_grant are never both high.
//  - Reset mid-transaction: immediate return to IDLE. The outstanding response is dropped.
// STRUCTURE
//  - Shared package imem_arb_pkg: state encoding constants (IDLE=2'd0, BUSY_IF=2'd1, BUSY_LD=2'd2), requester ids (REQ_IF=0, REQ_LD=1).
//  - One sub-module: imem_arb_rr. A 2-way round-robin pick plus the rr flop (inputs req[1:0], advance; output gnt[1:0]).
//  - FSM, command latch, response registers, kill flag and timeout counter stay in the top module.
// TESTING
//  1 Reset: hold reset=0 with if_req=1 -> every output 0. Release -> if_grant=1, mem_en=1, mem_addr=if_addr in the first cycle.
//  2 Fetch: if_addr=0x10, mem_ready 2 cycles after grant with mem_rdata=0x00500093 -> if_rvalid pulse with if_rdata=0x00500093.
//    fetch_stall is high from the request until the rvalid cycle.
//  3 Contention: if_req and ld_req held, ld_we=1, ld_addr=0x40, ld_wdata=0xDEADBEEF -> grants alternate IF, LD, IF, LD.
//    The LD command shows mem_we=1 with the same address and data, and ld_done pulses.
//  4 Flush: if_flush pulsed 1 cycle after if_grant (and separately on the mem_ready cycle) -> no if_rvalid pulse.
//    The next if_req is granted normally.
//  5 Timeout: grant a fetch, mem_ready never asserted -> after 15 busy cycles, return to IDLE with err=1 and no if_rvalid.
//    A late mem_ready is ignored.
//  6 Mid-op reset: reset=0 asserted in BUSY_LD -> outputs 0 asynchronously, no ld_done after release.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: state encodings and requester ids shared by the imem port arbiter and its round-robin picker.
package imem_arb_pkg;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_LD = 2'd2;
    localparam int REQ_IF = 0;
    localparam int REQ_LD = 1;
endpackage

// File: rtl/imem_arb_rr.sv
// imem_arb_rr: two-way round-robin pick between the IF and loader requesters, with its preference flop.
module imem_arb_rr
    import imem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ld_pref;

    always_comb begin
        gnt = '0;
        gnt[REQ_IF] = req[REQ_IF] & (~req[REQ_LD] | ~ld_pref);
        gnt[REQ_LD] = req[REQ_LD] & ~gnt[REQ_IF];
    end

    // after a grant the other requester becomes preferred
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ld_pref <= 1'b0;
        else if (advance)
            ld_pref <= gnt[REQ_IF];
    end
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port instruction memory between IF fetches and the loader/debug port,
// one outstanding transaction at a time, with flush kill and a ready timeout.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_grant,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              fetch_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_grant,
    output logic              ld_done,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state, req, gnt;
    logic [CNT_W-1:0]  cnt;
    logic              idle, kill, timeout, cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // requests are masked during reset so every output reads 0 while it is held
    assign idle = state == IDLE;
    assign req  = {ld_req, if_req} & {2{idle & reset}};

    imem_arb_rr u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .advance(mem_en),
        .gnt    (gnt)
    );

    assign if_grant    = gnt[REQ_IF];
    assign ld_grant    = gnt[REQ_LD];
    assign mem_en      = |gnt;
    assign mem_we      = if_grant ? 1'b0 : ld_grant ? ld_we : cmd_we;
    assign mem_addr    = if_grant ? if_addr : ld_grant ? ld_addr : cmd_addr;
    assign mem_wdata   = if_grant ? '0 : ld_grant ? ld_wdata : cmd_wdata;
    assign fetch_stall = (if_req & reset & ~if_grant) | (state == BUSY_IF);
    assign timeout     = ~mem_ready && cnt == CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            kill      <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ld_done   <= 1'b0;
            ld_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ld_done   <= 1'b0;
            if (idle) begin
                cnt  <= '0;
                kill <= 1'b0;
                if (mem_en) begin
                    state     <= if_grant ? BUSY_IF : BUSY_LD;
                    cmd_we    <= mem_we;
                    cmd_addr  <= mem_addr;
                    cmd_wdata <= mem_wdata;
                end
            end else if (mem_ready) begin
                state <= IDLE;
                if (state == BUSY_IF) begin
                    if_rdata  <= mem_rdata;
                    if_rvalid <= ~(kill | if_flush);
                end else begin
                    ld_rdata <= mem_rdata;
                    ld_done  <= 1'b1;
                end
            end else if (timeout) begin
                state <= IDLE;
                err   <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                kill <= kill | (if_flush & (state == BUSY_IF));
            end
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level reference model of the arbiter.
module tb_imem_port_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, ld_req = 1'b0, ld_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, ld_addr = '0, ld_wdata = '0, mem_rdata = '0;
    logic        if_grant, if_rvalid, fetch_stall, ld_grant, ld_done, mem_en, mem_we, err;
    logic [31:0] if_rdata, ld_rdata, mem_addr, mem_wdata;
    int          n_chk = 0, n_err = 0;

    // reference model: owner 0 = free, 1 = fetch outstanding, 2 = loader outstanding
    int          owner, waited;
    bit          pref_ld, killed, e_ig, e_lg, m_rv, m_done, m_err, m_we;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_ld_rdata;

    always #5 clk = ~clk;

    imem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_grant(if_grant),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .fetch_stall(fetch_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_grant(ld_grant), .ld_done(ld_done), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; waited = 0; pref_ld = 0; killed = 0; m_rv = 0; m_done = 0; m_err = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_ld_rdata = '0;
    endtask

    task automatic settle();
        #1;
        e_ig = reset && owner == 0 && if_req && (!ld_req || !pref_ld);
        e_lg = reset && owner == 0 && ld_req && !e_ig;
        chk("if_grant", if_grant, e_ig);
        chk("ld_grant", ld_grant, e_lg);
        chk("mem_en", mem_en, e_ig || e_lg);
        chk("mem_we", mem_we, e_ig ? 1'b0 : e_lg ? ld_we : m_we);
        chk("mem_addr", mem_addr, e_ig ? if_addr : e_lg ? ld_addr : m_addr);
        chk("mem_wdata", mem_wdata, e_ig ? 32'h0 : e_lg ? ld_wdata : m_wdata);
        chk("fetch_stall", fetch_stall, (reset && if_req && !e_ig) || owner == 1);
        chk("if_rvalid", if_rvalid, m_rv);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("ld_done", ld_done, m_done);
        chk("ld_rdata", ld_rdata, m_ld_rdata);
        chk("err", err, m_err);
    endtask

    task automatic adv();
        @(posedge clk);
        if (reset) begin
            m_rv = 0;
            m_done = 0;
            if (owner == 0) begin
                if (e_ig || e_lg) begin
                    owner = e_ig ? 1 : 2;
                    waited = 0;
                    killed = 0;
                    pref_ld = e_ig;
                    m_we = e_lg && ld_we;
                    m_addr = e_ig ? if_addr : ld_addr;
                    m_wdata = e_ig ? 32'h0 : ld_wdata;
                end
            end else if (mem_ready) begin
                if (owner == 1) begin
                    m_if_rdata = mem_rdata;
                    m_rv = !(killed || if_flush);
                end else begin
                    m_ld_rdata = mem_rdata;
                    m_done = 1;
                end
                owner = 0;
            end else begin
                waited++;
                if (owner == 1 && if_flush) killed = 1;
                if (waited == 15) begin
                    owner = 0;
                    m_err = 1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {if_req, if_flush, ld_req, ld_we, mem_ready} = '0;
        model_reset();
        settle();
        adv();
        reset = 1'b1;
    endtask

    initial begin
        // reset held with a pending fetch: everything must stay quiet
        if_req = 1'b1;
        if_addr = 32'h100;
        model_reset();
        settle();
        chk("t1_rst_grant", if_grant, 0);
        chk("t1_rst_stall", fetch_stall, 0);
        adv();
        settle();
        adv();
        reset = 1'b1;
        settle();
        chk("t1_grant", if_grant, 1);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_addr", mem_addr, 32'h100);
        adv();
        if_req = 1'b0; mem_ready = 1'b1;
        settle(); adv();

        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        settle();
        chk("t2_grant", if_grant, 1);
        chk("t2_addr", mem_addr, 32'h10);
        adv();
        if_req = 1'b0;
        settle();
        chk("t2_stall_busy", fetch_stall, 1);
        adv();
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        settle();
        chk("t2_stall_ready", fetch_stall, 1);
        adv();
        mem_ready = 1'b0;
        settle();
        chk("t2_rvalid", if_rvalid, 1);
        chk("t2_rdata", if_rdata, 32'h00500093);
        chk("t2_stall_done", fetch_stall, 0);
        adv();
        settle();
        chk("t2_rvalid_pulse", if_rvalid, 0);
        adv();

        do_reset();
        if_req = 1'b1; if_addr = 32'h20;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h40; ld_wdata = 32'hDEADBEEF;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (i % 2 == 0) begin
                chk("t3_if_grant", if_grant, (i % 4 == 0));
                chk("t3_ld_grant", ld_grant, (i % 4 == 2));
            end
            if (i == 2) begin
                chk("t3_ld_we", mem_we, 1);
                chk("t3_ld_addr", mem_addr, 32'h40);
                chk("t3_ld_wdata", mem_wdata, 32'hDEADBEEF);
            end
            if (i == 4) chk("t3_ld_done", ld_done, 1);
            adv();
        end

        do_reset();
        if_req = 1'b1; if_addr = 32'h30;
        settle(); adv();
        if_req = 1'b0; if_flush = 1'b1;
        settle(); adv();
        if_flush = 1'b0; mem_ready = 1'b1;
        settle(); adv();
        mem_ready = 1'b0;
        settle();
        chk("t4_kill_early", if_rvalid, 0);
        adv();
        if_req = 1'b1;
        settle(); adv();
        if_req = 1'b0; mem_ready = 1'b1; if_flush = 1'b1;
        settle(); adv();
        mem_ready = 1'b0; if_flush = 1'b0;
        settle();
        chk("t4_kill_ready", if_rvalid, 0);
        adv();
        if_req = 1'b1;
        settle();
        chk("t4_regrant", if_grant, 1);
        adv();
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234;
        settle(); adv();
        mem_ready = 1'b0;
        settle();
        chk("t4_rvalid", if_rvalid, 1);
        chk("t4_rdata", if_rdata, 32'h1234);
        adv();

        do_reset();
        if_req = 1'b1; if_addr = 32'h50;
        settle(); adv();
        if_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            settle();
            if (i == 14) chk("t5_err_early", err, 0);
            adv();
        end
        settle();
        chk("t5_err", err, 1);
        chk("t5_idle", fetch_stall, 0);
        chk("t5_no_rv", if_rvalid, 0);
        mem_ready = 1'b1;
        adv();
        mem_ready = 1'b0;
        settle();
        chk("t5_late_rv", if_rvalid, 0);
        chk("t5_sticky", err, 1);
        adv();

        do_reset();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h80;
        settle(); adv();
        ld_req = 1'b0;
        settle(); adv();
        reset = 1'b0;
        model_reset();
        settle();
        chk("t6_addr", mem_addr, 0);
        adv();
        reset = 1'b1; mem_ready = 1'b1;
        settle(); adv();
        mem_ready = 1'b0;
        settle();
        chk("t6_no_done", ld_done, 0);
        adv();

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || e_ig) begin
                if_req = $urandom_range(0, 2) != 0;
                if_addr = $urandom & ~32'h3;
            end
            if (!ld_req || e_lg) begin
                ld_req = $urandom_range(0, 3) == 0;
                ld_we = 1'($urandom_range(0, 1));
                ld_addr = $urandom & ~32'h3;
                ld_wdata = $urandom;
            end
            mem_ready = $urandom_range(0, 3) == 0;
            mem_rdata = $urandom;
            if_flush = $urandom_range(0, 7) == 0;
            settle();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
